// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture
// Brief    : Oscilloscope-style trigger with pre/post capture into a circular buffer
// Revision : 1.0 - initial release
// ============================================================================
module trigger_capture #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 256,
    parameter int AUTO_TIMEOUT = 65535,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_input,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] trigger_level,
    input  logic [DATA_W-1:0] hysteresis,
    input  logic [1:0]        edge_mode,
    input  logic              auto_en,
    input  logic              arm,
    input  logic [ADDR_W-1:0] pre_trigger,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              triggered_auto
);

    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_pre;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_rise_arm;
    logic                r_fall_arm;
    logic [ADDR_W-1:0]   r_start_addr;
    logic                r_auto;
    logic [DATA_W-1:0]   r_rd_data;

    logic [DATA_W:0]     w_lo_ext;
    logic [DATA_W:0]     w_hi_ext;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_hi;
    logic                w_rise_fire;
    logic                w_fall_fire;
    logic                w_edge_fire;
    logic                w_timeout;
    logic                w_trig;
    logic                w_arm_ok;
    logic                w_write;
    logic [ADDR_W-1:0]   w_remain;

    // Hysteresis thresholds are clamped to the sample range instead of wrapping.
    always_comb begin
        w_lo_ext = {1'b0, trigger_level} - {1'b0, hysteresis};
        w_hi_ext = {1'b0, trigger_level} + {1'b0, hysteresis};
        w_lo     = w_lo_ext[DATA_W] ? '0 : w_lo_ext[DATA_W-1:0];
        w_hi     = w_hi_ext[DATA_W] ? '1 : w_hi_ext[DATA_W-1:0];
    end

    always_comb begin
        w_rise_fire = r_rise_arm && (data_input >= trigger_level);
        w_fall_fire = r_fall_arm && (data_input <= trigger_level);
        case (r_mode)
            2'b00:   w_edge_fire = w_rise_fire;
            2'b01:   w_edge_fire = w_fall_fire;
            2'b10:   w_edge_fire = w_rise_fire || w_fall_fire;
            default: w_edge_fire = 1'b1;
        endcase
        w_timeout = auto_en && (r_tmo == c_tmo_last);
        w_trig    = (r_state == S_WAIT) && data_valid && (w_edge_fire || w_timeout);
        w_arm_ok  = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_write   = data_valid &&
                    ((r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST));
        w_remain  = c_last - r_pre;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        busy           = 1'b0;
        done           = 1'b0;
        triggered_auto = r_auto;
        rd_data        = r_rd_data;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (arm)
                    w_next = (pre_trigger == '0) ? S_WAIT : S_PRE;
            end
            S_PRE: begin
                busy = 1'b1;
                if (data_valid && (r_cnt == c_one))
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_trig)
                    w_next = (w_remain == '0) ? S_DONE : S_POST;
            end
            S_POST: begin
                busy = 1'b1;
                if (data_valid && (r_cnt == c_one))
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_pre        <= '0;
            r_mode       <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_rise_arm   <= 1'b0;
            r_fall_arm   <= 1'b0;
            r_start_addr <= '0;
            r_auto       <= 1'b0;
        end else begin
            if (w_write)
                r_wr_ptr <= r_wr_ptr + c_one;
            if (w_arm_ok) begin
                r_pre      <= pre_trigger;
                r_mode     <= edge_mode;
                r_cnt      <= pre_trigger;
                r_tmo      <= '0;
                r_rise_arm <= 1'b0;
                r_fall_arm <= 1'b0;
                r_auto     <= 1'b0;
            end else if (data_valid) begin
                case (r_state)
                    S_PRE: begin
                        r_cnt      <= r_cnt - c_one;
                        r_rise_arm <= r_rise_arm || (data_input < w_lo);
                        r_fall_arm <= r_fall_arm || (data_input > w_hi);
                    end
                    S_WAIT: begin
                        r_rise_arm <= r_rise_arm || (data_input < w_lo);
                        r_fall_arm <= r_fall_arm || (data_input > w_hi);
                        if (r_tmo != c_tmo_last)
                            r_tmo <= r_tmo + TMO_W'(1);
                        if (w_trig) begin
                            // The trigger sample lands at r_wr_ptr this cycle.
                            r_start_addr <= r_wr_ptr - r_pre;
                            r_cnt        <= w_remain;
                            r_auto       <= !w_edge_fire;
                        end
                    end
                    S_POST: r_cnt <= r_cnt - c_one;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_ptr] <= data_input;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= r_mem[r_start_addr + rd_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_capture
// Brief    : Directed self-checking bench with a readout scoreboard queue
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_input = '0;
    logic              data_valid = 1'b0;
    logic [DATA_W-1:0] trigger_level = 12'd20;
    logic [DATA_W-1:0] hysteresis = 12'd4;
    logic [1:0]        edge_mode = 2'b00;
    logic              auto_en = 1'b0;
    logic              arm = 1'b0;
    logic [ADDR_W-1:0] pre_trigger = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              triggered_auto;

    trigger_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AUTO_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .data_input(data_input), .data_valid(data_valid),
        .trigger_level(trigger_level), .hysteresis(hysteresis), .edge_mode(edge_mode),
        .auto_en(auto_en), .arm(arm), .pre_trigger(pre_trigger), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .triggered_auto(triggered_auto)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_fails  = 0;
    int                test_id  = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                ns, nc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [DATA_W-1:0] sample_of(input int k);
        int v;
        case (test_id)
            1: begin
                v = 60 - 2 * k;
                return (v < 0) ? '0 : DATA_W'(v);
            end
            2: begin
                case (k)
                    0, 2:    return 12'd18;
                    1, 3, 5: return 12'd22;
                    4:       return 12'd14;
                    default: return DATA_W'(100 + k - 6);
                endcase
            end
            3:       return 12'd5;
            default: return DATA_W'(2 * k);
        endcase
    endfunction

    task automatic start(input logic [1:0] mode, input int pre, input logic aen);
        edge_mode   = mode;
        pre_trigger = ADDR_W'(pre);
        auto_en     = aen;
        arm         = 1'b1;
        @(posedge clk); #1;
        arm         = 1'b0;
    endtask

    // Feeds samples until done or the cycle bound; stall=1 inserts an idle cycle after each sample.
    task automatic run_capture(input int stall, input int max_cycles, input int arm_cyc,
                               output int nsamp, output int ncyc);
        nsamp = 0;
        ncyc  = 0;
        while (done !== 1'b1 && ncyc < max_cycles) begin
            if (stall == 0 || ncyc % 2 == 0) begin
                data_valid = 1'b1;
                data_input = sample_of(nsamp);
            end else begin
                data_valid = 1'b0;
                data_input = 12'hABC;
            end
            arm = (ncyc == arm_cyc);
            @(posedge clk); #1;
            if (data_valid) nsamp++;
            ncyc++;
        end
        data_valid = 1'b0;
        arm        = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr, input int expv);
        exp_q.push_back(DATA_W'(expv));
        rd_addr = ADDR_W'(addr);
        @(posedge clk); #1;
        check($sformatf("%s rd[%0d]", tag, addr), 32'(rd_data), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #2;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset auto", 32'(triggered_auto), 0);
        check("reset rd_data", 32'(rd_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Rising edge, 4 pre-trigger samples, ramp 0,2,4,...
        test_id = 0;
        start(2'b00, 4, 1'b0);
        check("rise busy", 32'(busy), 1);
        run_capture(0, 200, -1, ns, nc);
        check("rise done", 32'(done), 1);
        check("rise busy end", 32'(busy), 0);
        check("rise samples", 32'(ns), 22);
        check("rise auto", 32'(triggered_auto), 0);
        read_check("rise", 0, 12);
        read_check("rise", 1, 14);
        read_check("rise", 4, 20);
        read_check("rise", 15, 42);
        check("rise done hold", 32'(done), 1);

        // Falling edge, no pre-trigger, ramp down from 60
        test_id = 1;
        start(2'b01, 0, 1'b0);
        run_capture(0, 200, -1, ns, nc);
        check("fall done", 32'(done), 1);
        check("fall samples", 32'(ns), 36);
        read_check("fall", 0, 20);
        read_check("fall", 9, 2);

        // Hysteresis: only the dip to 14 arms the rising trigger
        test_id = 2;
        start(2'b00, 0, 1'b0);
        run_capture(0, 200, -1, ns, nc);
        check("hyst done", 32'(done), 1);
        check("hyst samples", 32'(ns), 21);
        read_check("hyst", 0, 22);
        read_check("hyst", 1, 100);
        read_check("hyst", 15, 114);

        // Auto trigger on a flat signal
        test_id = 3;
        start(2'b00, 0, 1'b1);
        run_capture(0, 200, -1, ns, nc);
        check("auto done", 32'(done), 1);
        check("auto samples", 32'(ns), TMO + 15);
        check("auto flag", 32'(triggered_auto), 1);
        read_check("auto", 0, 5);
        read_check("auto", 15, 5);
        auto_en = 1'b0;

        // Stalled input with an arm pulse during POST
        test_id = 4;
        start(2'b00, 4, 1'b0);
        check("stall auto cleared", 32'(triggered_auto), 0);
        run_capture(1, 200, 30, ns, nc);
        check("stall done", 32'(done), 1);
        check("stall samples", 32'(ns), 22);
        check("stall cycles", 32'(nc), 43);
        read_check("stall", 0, 12);
        read_check("stall", 4, 20);
        read_check("stall", 15, 42);

        // Reset in the middle of POST, then a fresh capture
        test_id = 5;
        start(2'b00, 4, 1'b0);
        run_capture(0, 15, -1, ns, nc);
        check("abort busy before", 32'(busy), 1);
        check("abort done before", 32'(done), 0);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort auto", 32'(triggered_auto), 0);
        check("abort rd_data", 32'(rd_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start(2'b00, 4, 1'b0);
        run_capture(0, 200, -1, ns, nc);
        check("rearm done", 32'(done), 1);
        check("rearm samples", 32'(ns), 22);
        read_check("rearm", 0, 12);
        read_check("rearm", 4, 20);
        read_check("rearm", 15, 42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
